// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle RV32I controller: opcodes, FSM states,
// ALU operation classes, ALU control codes and datapath mux select codes.
package multicycle_controller_pkg;

  // Opcodes recognised by the controller (instr[6:0])
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // One state per clock; encodings are visible on the debug state port
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  // ALU operation class requested by the main FSM
  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_t;

  // ALU control codes
  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_AND = 3'b010;
  localparam logic [2:0] ALUC_OR  = 3'b011;
  localparam logic [2:0] ALUC_SLT = 3'b101;

  // Result mux
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU A mux
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  // ALU B mux
  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  // Immediate formats
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format depends only on the opcode
  function automatic logic [1:0] imm_src_for(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps the FSM's ALU operation class plus instruction funct
// fields onto the ALU control code.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  // Only R-type (op5=1) with funct7b5 set selects subtract; I-type addi never does
  always_comb begin
    alu_control = ALUC_ADD;
    case (alu_op_t'(alu_op))
      ALU_OP_ADD: alu_control = ALUC_ADD;
      ALU_OP_SUB: alu_control = ALUC_SUB;
      ALU_OP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 & funct7b5) ? ALUC_SUB : ALUC_ADD;
          3'b010:  alu_control = ALUC_SLT;
          3'b110:  alu_control = ALUC_OR;
          3'b111:  alu_control = ALUC_AND;
          default: alu_control = ALUC_ADD;
        endcase
      end
      default: alu_control = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: sequences the shared
// memory/ALU datapath through fetch, decode, execute and writeback steps.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int unsigned STATE_W = 4,
  parameter int unsigned ALUC_W  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUC_W-1:0]  alu_control,
  output logic               reg_write,
  output logic [1:0]         imm_src,
  output logic [STATE_W-1:0] state
);

  state_t     state_q, state_d;
  alu_op_t    alu_op;
  logic       pc_update;
  logic       branch;
  logic [2:0] aluc;

  // State register; reset returns to FETCH immediately, even mid-instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and Moore outputs; unlisted enables are 0, unlisted selects 00
  always_comb begin
    state_d    = S_FETCH;
    alu_op     = ALU_OP_ADD;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        pc_update  = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ITYPE:     state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        state_d   = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        result_src = RES_ALUOUT;
        adr_src    = 1'b1;
        state_d    = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        result_src = RES_ALUOUT;
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_RD2;
        alu_op    = ALU_OP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_OP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALU_OP_SUB;
        result_src = RES_ALUOUT;
        branch     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_update  = 1'b1;
        state_d    = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign pc_write    = pc_update | (branch & zero);
  assign imm_src     = imm_src_for(op);
  assign alu_control = ALUC_W'(aluc);
  assign state       = STATE_W'(state_q);

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (aluc)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller: walks each
// instruction class through its state sequence and checks outputs per state.
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  int unsigned compared;
  int unsigned mismatched;

  multicycle_controller #(.STATE_W(4), .ALUC_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .reg_write   (reg_write),
    .imm_src     (imm_src),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one active edge and settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    op         = 7'b0000011;
    funct3     = 3'b000;
    funct7b5   = 1'b0;
    zero       = 1'b0;
    #2;
    chk("reset_state", 8'(state), 8'd0);
    chk("reset_ir_write", 8'(ir_write), 8'd1);
    chk("reset_mem_write", 8'(mem_write), 8'd0);
    chk("reset_reg_write", 8'(reg_write), 8'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // lw: 0,1,2,3,4,0
    chk("lw_fetch_state", 8'(state), 8'd0);
    chk("lw_fetch_pc_write", 8'(pc_write), 8'd1);
    chk("lw_fetch_result_src", 8'(result_src), 8'b10);
    chk("lw_fetch_src_b", 8'(alu_src_b), 8'b10);
    chk("lw_fetch_adr_src", 8'(adr_src), 8'd0);
    tick();
    chk("lw_decode_state", 8'(state), 8'd1);
    chk("lw_decode_src_a", 8'(alu_src_a), 8'b01);
    chk("lw_decode_src_b", 8'(alu_src_b), 8'b01);
    chk("lw_decode_ir_write", 8'(ir_write), 8'd0);
    tick();
    chk("lw_memadr_state", 8'(state), 8'd2);
    chk("lw_memadr_src_a", 8'(alu_src_a), 8'b10);
    chk("lw_imm_src", 8'(imm_src), 8'b00);
    chk("lw_memadr_reg_write", 8'(reg_write), 8'd0);
    tick();
    chk("lw_memread_state", 8'(state), 8'd3);
    chk("lw_memread_adr_src", 8'(adr_src), 8'd1);
    chk("lw_memread_reg_write", 8'(reg_write), 8'd0);
    tick();
    chk("lw_memwb_state", 8'(state), 8'd4);
    chk("lw_memwb_reg_write", 8'(reg_write), 8'd1);
    chk("lw_memwb_result_src", 8'(result_src), 8'b01);
    tick();
    chk("lw_done_state", 8'(state), 8'd0);
    chk("lw_done_reg_write", 8'(reg_write), 8'd0);

    // sw: 0,1,2,5,0
    op = 7'b0100011;
    tick();
    chk("sw_decode_state", 8'(state), 8'd1);
    chk("sw_imm_src", 8'(imm_src), 8'b01);
    tick();
    chk("sw_memadr_state", 8'(state), 8'd2);
    chk("sw_memadr_mem_write", 8'(mem_write), 8'd0);
    tick();
    chk("sw_memwrite_state", 8'(state), 8'd5);
    chk("sw_memwrite_mem_write", 8'(mem_write), 8'd1);
    chk("sw_memwrite_adr_src", 8'(adr_src), 8'd1);
    chk("sw_memwrite_reg_write", 8'(reg_write), 8'd0);
    tick();
    chk("sw_done_state", 8'(state), 8'd0);
    chk("sw_done_mem_write", 8'(mem_write), 8'd0);

    // R-type sub: 0,1,6,8,0
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    tick();
    chk("rsub_decode_state", 8'(state), 8'd1);
    chk("rsub_decode_aluc", 8'(alu_control), 8'b000);
    tick();
    chk("rsub_execr_state", 8'(state), 8'd6);
    chk("rsub_execr_aluc", 8'(alu_control), 8'b001);
    chk("rsub_execr_src_b", 8'(alu_src_b), 8'b00);
    chk("rsub_execr_src_a", 8'(alu_src_a), 8'b10);
    tick();
    chk("rsub_aluwb_state", 8'(state), 8'd8);
    chk("rsub_aluwb_reg_write", 8'(reg_write), 8'd1);
    chk("rsub_aluwb_result_src", 8'(result_src), 8'b00);
    tick();
    chk("rsub_done_state", 8'(state), 8'd0);

    // Same funct fields on I-type: funct7b5 must not turn addi into sub
    op = 7'b0010011;
    tick();
    tick();
    chk("iadd_execi_state", 8'(state), 8'd7);
    chk("iadd_execi_aluc", 8'(alu_control), 8'b000);
    chk("iadd_execi_src_b", 8'(alu_src_b), 8'b01);
    tick();
    chk("iadd_aluwb_state", 8'(state), 8'd8);
    tick();
    chk("iadd_done_state", 8'(state), 8'd0);

    // R-type or / and / slt decode in EXECR
    op = 7'b0110011; funct3 = 3'b110; funct7b5 = 1'b0;
    tick(); tick();
    chk("ror_execr_aluc", 8'(alu_control), 8'b011);
    tick(); tick();
    funct3 = 3'b111;
    tick(); tick();
    chk("rand_execr_aluc", 8'(alu_control), 8'b010);
    tick(); tick();
    funct3 = 3'b010;
    tick(); tick();
    chk("rslt_execr_aluc", 8'(alu_control), 8'b101);
    tick(); tick();
    chk("rslt_done_state", 8'(state), 8'd0);

    // beq taken: 0,1,9,0
    op = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
    tick();
    chk("beqt_imm_src", 8'(imm_src), 8'b10);
    tick();
    chk("beqt_state", 8'(state), 8'd9);
    chk("beqt_pc_write", 8'(pc_write), 8'd1);
    chk("beqt_aluc", 8'(alu_control), 8'b001);
    tick();
    chk("beqt_done_state", 8'(state), 8'd0);

    // beq not taken
    zero = 1'b0;
    tick(); tick();
    chk("beqn_state", 8'(state), 8'd9);
    chk("beqn_pc_write", 8'(pc_write), 8'd0);
    tick();
    chk("beqn_done_state", 8'(state), 8'd0);

    // jal: 0,1,10,8,0
    op = 7'b1101111;
    tick();
    chk("jal_imm_src", 8'(imm_src), 8'b11);
    tick();
    chk("jal_state", 8'(state), 8'd10);
    chk("jal_pc_write", 8'(pc_write), 8'd1);
    chk("jal_src_a", 8'(alu_src_a), 8'b01);
    chk("jal_src_b", 8'(alu_src_b), 8'b10);
    tick();
    chk("jal_aluwb_state", 8'(state), 8'd8);
    chk("jal_aluwb_reg_write", 8'(reg_write), 8'd1);
    tick();
    chk("jal_done_state", 8'(state), 8'd0);

    // Unknown opcode: 0,1,0 with no writes
    op = 7'b1111111;
    chk("unk_fetch_wr", 8'({reg_write, mem_write}), 8'd0);
    tick();
    chk("unk_decode_state", 8'(state), 8'd1);
    chk("unk_decode_wr", 8'({reg_write, mem_write}), 8'd0);
    tick();
    chk("unk_done_state", 8'(state), 8'd0);
    chk("unk_done_wr", 8'({reg_write, mem_write}), 8'd0);

    // Asynchronous reset in the middle of MEMWRITE
    op = 7'b0100011;
    tick(); tick(); tick();
    chk("rst_pre_state", 8'(state), 8'd5);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_mid_state", 8'(state), 8'd0);
    chk("rst_mid_mem_write", 8'(mem_write), 8'd0);
    chk("rst_mid_ir_write", 8'(ir_write), 8'd1);
    chk("rst_mid_pc_write", 8'(pc_write), 8'd1);
    tick();
    chk("rst_held_state", 8'(state), 8'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("rst_after_state", 8'(state), 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
